// File: rtl/alu_operand_sequencer_if.sv
// Handshake and datapath bundle between an operand source, the sequencer and
// the external combinational unit.
interface alu_operand_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_s;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_parity;
    logic             busy;

    // The master side plays both the request source and the combinational unit.
    modport master (
        output in_valid, in_a, in_b, in_op, alu_s, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result,
               out_zero, out_parity, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, alu_s, out_ready,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_result,
               out_zero, out_parity, busy
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Registers operands for an external combinational unit, waits SETTLE_CYCLES
// edges for it to settle, then captures and holds the result with flags.
module alu_operand_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    alu_operand_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic             valid_q, valid_d;
    logic             in_ready;
    logic             accept;

    // Ready is a pure function of state and downstream ready, so a held result
    // can be consumed and replaced on the same edge.
    assign in_ready = (state_q == IDLE) || (state_q == HOLD && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets its default before the case so no path leaves
        // it unassigned and infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        valid_d  = valid_q;

        if (accept) begin
            alu_a_d  = bus.in_a;
            alu_b_d  = bus.in_b;
            alu_op_d = bus.in_op;
            cnt_d    = 4'd0;
            valid_d  = 1'b0;
            state_d  = SETTLE;
        end else begin
            case (state_q)
                SETTLE: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        // Flags come from alu_s itself, not from the stored result.
                        result_d = bus.alu_s;
                        zero_d   = (bus.alu_s == '0);
                        parity_d = ^bus.alu_s;
                        valid_d  = 1'b1;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: reset is sampled on the clock edge only, and state uses
    // non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 2'b00;
            result_q <= '0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_result = result_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_parity = parity_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
